// File: rtl/pcm_float_feeder.sv
// ============================================================================
// Module      : pcm_float_feeder
// Description : Sign-extends I2S PCM samples and sequences them through the
//               multi-cycle FPU port (int-to-float, then optional gain
//               multiply), presenting the float result on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcm_float_feeder #(
    parameter int         SAMPLE_W = 24,
    parameter int         CH_W     = 3,
    parameter logic [2:0] OP_I2F   = 3'd2,
    parameter logic [2:0] OP_MUL   = 3'd4,
    parameter int         TIMEOUT  = 64
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [SAMPLE_W-1:0] pcm_data,
    input  logic [CH_W-1:0]     pcm_chan,
    input  logic                pcm_valid,
    output logic                pcm_ready,
    input  logic [31:0]         gain,
    output logic                fpu_clk_en,
    output logic                fpu_start,
    output logic [2:0]          fpu_n,
    output logic [31:0]         fpu_dataa,
    output logic [31:0]         fpu_datab,
    input  logic                fpu_done,
    input  logic [31:0]         fpu_result,
    output logic [31:0]         out_data,
    output logic [CH_W-1:0]     out_chan,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                err_timeout
);

    localparam logic [31:0] c_GAIN_ONE = 32'h3F80_0000;
    localparam int          c_CNT_W    = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CVT_GO   = 3'd1,
        S_CVT_WAIT = 3'd2,
        S_MUL_GO   = 3'd3,
        S_MUL_WAIT = 3'd4,
        S_OUT      = 3'd5
    } state_t;

    state_t               state_q;
    logic                 pcm_ready_q;
    logic                 fpu_clk_en_q;
    logic                 fpu_start_q;
    logic [2:0]           fpu_n_q;
    logic [31:0]          fpu_dataa_q;
    logic [31:0]          fpu_datab_q;
    logic [31:0]          out_data_q;
    logic [CH_W-1:0]      out_chan_q;
    logic                 out_valid_q;
    logic                 err_timeout_q;
    logic [31:0]          gain_q;
    logic [CH_W-1:0]      chan_q;
    logic [c_CNT_W-1:0]   wait_cnt_q;

    logic [31:0]          w_sample_ext;

    assign w_sample_ext = {{(32 - SAMPLE_W){pcm_data[SAMPLE_W-1]}}, pcm_data};

    // Every output comes straight from a register so the FPU sees clean,
    // glitch-free operands and a single-cycle start pulse.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= S_IDLE;
            pcm_ready_q   <= 1'b0;
            fpu_clk_en_q  <= 1'b0;
            fpu_start_q   <= 1'b0;
            fpu_n_q       <= 3'd0;
            fpu_dataa_q   <= 32'd0;
            fpu_datab_q   <= 32'd0;
            out_data_q    <= 32'd0;
            out_chan_q    <= '0;
            out_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            gain_q        <= 32'd0;
            chan_q        <= '0;
            wait_cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pcm_ready_q <= 1'b1;
                    if (pcm_valid && pcm_ready_q) begin
                        pcm_ready_q  <= 1'b0;
                        gain_q       <= gain;
                        chan_q       <= pcm_chan;
                        fpu_clk_en_q <= 1'b1;
                        fpu_start_q  <= 1'b1;
                        fpu_n_q      <= OP_I2F;
                        fpu_dataa_q  <= w_sample_ext;
                        fpu_datab_q  <= 32'd0;
                        state_q      <= S_CVT_GO;
                    end
                end

                S_CVT_GO: begin
                    fpu_start_q <= 1'b0;
                    wait_cnt_q  <= '0;
                    state_q     <= S_CVT_WAIT;
                end

                S_MUL_GO: begin
                    fpu_start_q <= 1'b0;
                    wait_cnt_q  <= '0;
                    state_q     <= S_MUL_WAIT;
                end

                S_CVT_WAIT, S_MUL_WAIT: begin
                    if (fpu_done) begin
                        if (state_q == S_CVT_WAIT && gain_q != c_GAIN_ONE) begin
                            fpu_start_q <= 1'b1;
                            fpu_n_q     <= OP_MUL;
                            fpu_dataa_q <= fpu_result;
                            fpu_datab_q <= gain_q;
                            state_q     <= S_MUL_GO;
                        end else begin
                            fpu_clk_en_q <= 1'b0;
                            out_data_q   <= fpu_result;
                            out_chan_q   <= chan_q;
                            out_valid_q  <= 1'b1;
                            state_q      <= S_OUT;
                        end
                    end else if (wait_cnt_q == c_CNT_LAST) begin
                        // Abandon the sample; the flag stays up until reset.
                        err_timeout_q <= 1'b1;
                        fpu_clk_en_q  <= 1'b0;
                        pcm_ready_q   <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + c_CNT_W'(1);
                    end
                end

                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        pcm_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    fpu_clk_en_q <= 1'b0;
                    fpu_start_q  <= 1'b0;
                    out_valid_q  <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign pcm_ready   = pcm_ready_q;
    assign fpu_clk_en  = fpu_clk_en_q;
    assign fpu_start   = fpu_start_q;
    assign fpu_n       = fpu_n_q;
    assign fpu_dataa   = fpu_dataa_q;
    assign fpu_datab   = fpu_datab_q;
    assign out_data    = out_data_q;
    assign out_chan    = out_chan_q;
    assign out_valid   = out_valid_q;
    assign err_timeout = err_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_pcm_float_feeder.sv
// ============================================================================
// Module      : tb_pcm_float_feeder
// Description : Self-checking bench for pcm_float_feeder with a behavioural
//               fixed-latency FPU returning hand-computed results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcm_float_feeder;

    localparam int         SAMPLE_W = 24;
    localparam int         CH_W     = 3;
    localparam logic [2:0] OP_I2F   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd4;
    localparam int         TIMEOUT  = 64;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [SAMPLE_W-1:0] pcm_data;
    logic [CH_W-1:0]     pcm_chan;
    logic                pcm_valid;
    logic                pcm_ready;
    logic [31:0]         gain;
    logic                fpu_clk_en;
    logic                fpu_start;
    logic [2:0]          fpu_n;
    logic [31:0]         fpu_dataa;
    logic [31:0]         fpu_datab;
    logic                fpu_done;
    logic [31:0]         fpu_result = 32'd0;
    logic [31:0]         out_data;
    logic [CH_W-1:0]     out_chan;
    logic                out_valid;
    logic                out_ready;
    logic                err_timeout;

    always #5 clk = ~clk;

    pcm_float_feeder #(
        .SAMPLE_W (SAMPLE_W),
        .CH_W     (CH_W),
        .OP_I2F   (OP_I2F),
        .OP_MUL   (OP_MUL),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (reset_n),
        .pcm_data      (pcm_data),
        .pcm_chan      (pcm_chan),
        .pcm_valid     (pcm_valid),
        .pcm_ready     (pcm_ready),
        .gain          (gain),
        .fpu_clk_en    (fpu_clk_en),
        .fpu_start     (fpu_start),
        .fpu_n         (fpu_n),
        .fpu_dataa     (fpu_dataa),
        .fpu_datab     (fpu_datab),
        .fpu_done      (fpu_done),
        .fpu_result    (fpu_result),
        .out_data      (out_data),
        .out_chan      (out_chan),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .err_timeout   (err_timeout)
    );

    // FPU model: logs every start, answers after fpu_lat cycles.
    logic        model_done = 1'b0;
    logic        stray_done;
    int          nstarts = 0;
    int          cd = 0;
    logic [2:0]  pend_n = 3'd0;
    logic [2:0]  log_n [0:255];
    logic [31:0] log_a [0:255];
    logic [31:0] log_b [0:255];
    int          fpu_lat;
    bit          fpu_en;
    logic [31:0] res_cvt;
    logic [31:0] res_mul;

    assign fpu_done = model_done | stray_done;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (fpu_start) begin
            log_n[nstarts[7:0]] <= fpu_n;
            log_a[nstarts[7:0]] <= fpu_dataa;
            log_b[nstarts[7:0]] <= fpu_datab;
            nstarts <= nstarts + 1;
            pend_n  <= fpu_n;
            cd      <= fpu_lat;
        end else if (cd > 0) begin
            cd <= cd - 1;
            if (cd == 1 && fpu_en) begin
                model_done <= 1'b1;
                fpu_result <= (pend_n == OP_I2F) ? res_cvt : res_mul;
            end
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic [23:0] data;
        logic [2:0]  chan;
        logic [31:0] gain;
        logic [31:0] cvt_res;
        logic [31:0] mul_res;
        logic [31:0] exp_out;
        int          exp_starts;
        logic [31:0] exp_a;
    } vec_t;

    vec_t vecs [5];

    task automatic send(input logic [23:0] d, input logic [2:0] c, input logic [31:0] g);
        int n;
        @(negedge clk);
        pcm_data  = d;
        pcm_chan  = c;
        gain      = g;
        pcm_valid = 1'b1;
        n = 0;
        while (!pcm_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(pcm_ready), 32'd1);
        @(posedge clk);
        #1;
        pcm_valid = 1'b0;
        pcm_data  = '0;
        gain      = ~g;
    endtask

    task automatic run_vec(input vec_t v, input int hold);
        int n, base, viol, base2;
        res_cvt = v.cvt_res;
        res_mul = v.mul_res;
        base = nstarts;
        send(v.data, v.chan, v.gain);
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        chk("start_count", 32'(nstarts - base), 32'(v.exp_starts));
        chk("cvt_n", 32'(log_n[8'(base)]), 32'(OP_I2F));
        chk("cvt_dataa", log_a[8'(base)], v.exp_a);
        chk("cvt_datab", log_b[8'(base)], 32'd0);
        if (v.exp_starts == 2) begin
            chk("mul_n", 32'(log_n[8'(base + 1)]), 32'(OP_MUL));
            chk("mul_dataa", log_a[8'(base + 1)], v.cvt_res);
            chk("mul_datab", log_b[8'(base + 1)], v.gain);
        end
        chk("out_data", out_data, v.exp_out);
        chk("out_chan", 32'(out_chan), 32'(v.chan));
        viol  = 0;
        base2 = nstarts;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (out_data !== v.exp_out || out_chan !== v.chan || !out_valid || pcm_ready || fpu_start)
                viol++;
        end
        if (hold > 0) begin
            chk("bp_stable", 32'(viol), 32'd0);
            chk("bp_no_start", 32'(nstarts - base2), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("ready_after_hs", 32'(pcm_ready), 32'd1);
        chk("valid_dropped", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n, viol, seen_v, seen_d;
        vecs[0] = '{data:24'h000001, chan:3'd0, gain:32'h3F800000, cvt_res:32'h3F800000,
                    mul_res:32'hDEADBEEF, exp_out:32'h3F800000, exp_starts:1, exp_a:32'h00000001};
        vecs[1] = '{data:24'h800000, chan:3'd5, gain:32'h3F000000, cvt_res:32'hCB000000,
                    mul_res:32'hCA800000, exp_out:32'hCA800000, exp_starts:2, exp_a:32'hFF800000};
        vecs[2] = '{data:24'h000003, chan:3'd2, gain:32'h40000000, cvt_res:32'h40400000,
                    mul_res:32'h40C00000, exp_out:32'h40C00000, exp_starts:2, exp_a:32'h00000003};
        vecs[3] = '{data:24'hFFFFFF, chan:3'd7, gain:32'h3F800000, cvt_res:32'hBF800000,
                    mul_res:32'hDEADBEEF, exp_out:32'hBF800000, exp_starts:1, exp_a:32'hFFFFFFFF};
        vecs[4] = '{data:24'h7FFFFF, chan:3'd1, gain:32'h00000000, cvt_res:32'h4AFFFFFE,
                    mul_res:32'h00000000, exp_out:32'h00000000, exp_starts:2, exp_a:32'h007FFFFF};

        reset_n    = 1'b0;
        pcm_data   = '0;
        pcm_chan   = '0;
        pcm_valid  = 1'b0;
        gain       = 32'd0;
        out_ready  = 1'b0;
        stray_done = 1'b0;
        fpu_lat    = 4;
        fpu_en     = 1'b1;
        res_cvt    = 32'd0;
        res_mul    = 32'd0;

        @(negedge clk);
        @(negedge clk);
        chk("reset_ctrl", {27'd0, pcm_ready, fpu_start, fpu_clk_en, out_valid, err_timeout}, 32'd0);
        chk("reset_fpu_n", 32'(fpu_n), 32'd0);
        chk("reset_dataa", fpu_dataa, 32'd0);
        chk("reset_datab", fpu_datab, 32'd0);
        chk("reset_out", {out_data[31:3], out_data[2:0] | out_chan}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(pcm_ready), 32'd1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], (i == 1) ? 20 : 0);

        // Stray done while idle must not disturb anything.
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        viol = 0;
        for (int i = 0; i < 3; i++) begin
            if (!pcm_ready || fpu_start || fpu_clk_en || out_valid) viol++;
            @(negedge clk);
        end
        chk("stray_done_ignored", 32'(viol), 32'd0);

        // FPU never answers: timeout.
        fpu_en = 1'b0;
        send(24'h000010, 3'd3, 32'h3F800000);
        @(negedge clk);
        chk("timeout_start", 32'(fpu_start), 32'd1);
        n = 0;
        seen_v = 0;
        while (!err_timeout && n < 200) begin
            @(negedge clk);
            n++;
            if (out_valid) seen_v = 1;
        end
        chk("timeout_latency", 32'(n - 1), 32'(TIMEOUT));
        chk("timeout_flag", 32'(err_timeout), 32'd1);
        chk("timeout_no_out", 32'(seen_v), 32'd0);
        chk("timeout_idle", {30'd0, pcm_ready, fpu_clk_en}, 32'd2);
        fpu_en = 1'b1;
        run_vec(vecs[2], 0);
        chk("timeout_sticky", 32'(err_timeout), 32'd1);

        // Reset during MUL_WAIT, with a late done arriving afterwards.
        fpu_lat = 12;
        res_cvt = 32'h40400000;
        res_mul = 32'h40C00000;
        send(24'h000003, 3'd6, 32'h40000000);
        n = 0;
        while (!(fpu_start && fpu_n == OP_MUL) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mul_start_seen", {31'd0, fpu_start}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ctrl", {27'd0, pcm_ready, fpu_start, fpu_clk_en, out_valid, err_timeout}, 32'd0);
        chk("arst_fpu_n", 32'(fpu_n), 32'd0);
        chk("arst_dataa", fpu_dataa, 32'd0);
        chk("arst_datab", fpu_datab, 32'd0);
        chk("arst_out", out_data, 32'd0);
        chk("arst_chan", 32'(out_chan), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("arst_ready", 32'(pcm_ready), 32'd1);
        viol = 0;
        seen_d = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (model_done) seen_d = 1;
            if (out_valid || fpu_start || fpu_clk_en || !pcm_ready) viol++;
        end
        chk("late_done_seen", 32'(seen_d), 32'd1);
        chk("late_done_ignored", 32'(viol), 32'd0);
        fpu_lat = 4;
        run_vec(vecs[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pcm_float_feeder.md
Name: pcm_float_feeder

Overview:
- Upstream feeder for the multi-cycle (s2) port of the Nios floating-point custom-instruction unit in the mic-array I2S audio path.
- Accepts signed PCM samples from the I2S receiver and sign-extends each one.
- Drives the FPU through two ops: int-to-float conversion, then multiply by a float gain. The multiply is skipped when the gain is exactly 1.0.
- Presents the float result and channel tag on a valid/ready output stream.

Parameters:
- SAMPLE_W, 24, PCM sample width (signed, two's complement).
- CH_W, 3, channel tag width.
- OP_I2F, 3'd2, FPU n code for int-to-float conversion.
- OP_MUL, 3'd4, FPU n code for float multiply.
- TIMEOUT, 64, maximum cycles to wait for fpu_done before aborting.

Ports:
- clk_clk in 1 system clock
- reset_reset_n in 1 asynchronous active-low reset
- pcm_data in SAMPLE_W input sample
- pcm_chan in CH_W input channel tag
- pcm_valid in 1 input sample valid
- pcm_ready out 1 block can accept a sample
- gain in 32 IEEE-754 single gain, sampled at acceptance
- fpu_clk_en out 1 FPU clock enable
- fpu_start out 1 one-cycle op start pulse
- fpu_n out 3 op select
- fpu_dataa out 32 operand A
- fpu_datab out 32 operand B
- fpu_done in 1 op complete
- fpu_result in 32 op result
- out_data out 32 float result
- out_chan out CH_W result channel tag
- out_valid out 1 result valid
- out_ready in 1 downstream accepts result
- err_timeout out 1 sticky timeout flag

Behaviour:
- Reset: asynchronous, active-low; every register is cleared immediately on assertion.
  - Outputs at reset: pcm_ready=0, fpu_start=0, fpu_clk_en=0, fpu_n=0, fpu_dataa=0, fpu_datab=0, out_valid=0, out_data=0, out_chan=0, err_timeout=0.
  - First cycle after release: state=IDLE, pcm_ready=1.
- States: IDLE, CVT_GO, CVT_WAIT, MUL_GO, MUL_WAIT, OUT.
- IDLE:
  - pcm_ready=1.
  - On pcm_valid&pcm_ready, latch sign_extend(pcm_data) to 32 bits, pcm_chan and gain; go to CVT_GO.
- CVT_GO:
  - fpu_start=1 for exactly one cycle, fpu_n=OP_I2F, fpu_dataa=extended sample, fpu_datab=0.
  - Go to CVT_WAIT.
- CVT_WAIT:
  - fpu_done is sampled only in WAIT states, so it is never honoured in the same cycle as start.
  - On fpu_done, capture fpu_result. If latched gain==32'h3F800000, go to OUT; otherwise go to MUL_GO.
- MUL_GO:
  - fpu_start=1 for one cycle, fpu_n=OP_MUL, fpu_dataa=converted value, fpu_datab=latched gain.
  - Go to MUL_WAIT.
- MUL_WAIT: on fpu_done, capture fpu_result and go to OUT.
- Operand stability: fpu_n, fpu_dataa and fpu_datab are registered and held from the GO cycle until done is seen.
- fpu_clk_en=1 in every state except IDLE and OUT.
- OUT:
  - out_valid=1; out_data and out_chan are held stable until out_ready.
  - On out_valid&out_ready, go to IDLE. pcm_ready reasserts the next cycle, so throughput is at most one sample per (FPU latency + overhead).
- Timeout:
  - An 8-bit (clog2) wait counter clears on entry to each WAIT state.
  - If it reaches TIMEOUT-1 without fpu_done: set err_timeout, drop the sample (no output) and return to IDLE.
  - err_timeout clears only on reset.
- fpu_done outside WAIT states is ignored.
- gain changes while a sample is in flight do not affect that sample.
- Reset asserted mid-operation aborts the op with no partial output; the FPU sees fpu_clk_en=0 and fpu_start=0 immediately.

Test Plan:
- Sample 24'h000001, gain 32'h3F800000, model FPU with done after 4 cycles returning 32'h3F800000
  -> exactly one fpu_start with fpu_n=OP_I2F, fpu_dataa=32'h00000001, no MUL op, out_data=32'h3F800000.
- Sample 24'h800000, chan 5, gain 32'h3F000000
  -> conversion with fpu_dataa=32'hFF800000; then MUL with fpu_datab=32'h3F000000 and dataa equal to the conversion result; out_chan=5; two start pulses total.
- Hold out_ready=0 for 20 cycles after out_valid
  -> out_data/out_chan stable, pcm_ready=0, no fpu_start; one handshake when out_ready rises, then pcm_ready=1 the next cycle.
- FPU never asserts done
  -> err_timeout=1 exactly TIMEOUT cycles after the WAIT entry, no out_valid, return to IDLE; next sample processes normally and err_timeout stays 1.
- Assert reset_reset_n=0 during MUL_WAIT
  -> all outputs 0 asynchronously; after release pcm_ready=1; a late fpu_done pulse is ignored.
- Stray fpu_done in IDLE, and gain changed mid-conversion
  -> no state change or output from the stray done; the multiply uses the gain latched at acceptance.
